// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline status and hazard control signal bundle
// master = hazard controller, slave = pipeline datapath / data-memory side.
interface pipeline_hazard_ctrl_if;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       idex_memread;
   logic [4:0] idex_rd;
   logic       exmem_branch;
   logic       exmem_zero;
   logic       exmem_memread;
   logic       exmem_memwrite;
   logic       dmem_ready;
   logic       pc_write;
   logic       pc_src;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idex_write;
   logic       idex_flush;
   logic       exmem_write;
   logic       exmem_flush;
   logic       memwb_bubble;
   logic       dmem_req;
   logic       mem_stall;
   logic       mem_err;

   modport master (
      input  id_rs1, id_rs2, idex_memread, idex_rd, exmem_branch, exmem_zero,
             exmem_memread, exmem_memwrite, dmem_ready,
      output pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_flush, memwb_bubble, dmem_req, mem_stall, mem_err
   );

   modport slave (
      output id_rs1, id_rs2, idex_memread, idex_rd, exmem_branch, exmem_zero,
             exmem_memread, exmem_memwrite, dmem_ready,
      input  pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_flush, memwb_bubble, dmem_req, mem_stall, mem_err
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush/freeze sequencer
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   pipeline_hazard_ctrl_if.master  hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]        stall_cycles,
   output logic [CNT_W-1:0]        flush_events,
   output logic [CNT_W-1:0]        mem_wait_cycles
`endif
);

   localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t         state;
   logic [WCW-1:0] wait_cnt;
   logic           mem_err_q;

   logic memop;
   logic timeout;
   logic freeze;
   logic br_taken;
   logic lu_hazard;
   logic lu_stall;

   assign memop   = hz.exmem_memread | hz.exmem_memwrite;
   assign timeout = (wait_cnt == WCW'(MEM_TIMEOUT));

   // A timed-out access releases the pipeline as if it had completed.
   always_comb begin
      freeze = 1'b0;
      if (state == RUN)
         freeze = memop & ~hz.dmem_ready;
      else
         freeze = ~hz.dmem_ready & ~timeout;
   end

   assign br_taken  = ~freeze & hz.exmem_branch & hz.exmem_zero;
   assign lu_hazard = hz.idex_memread & (hz.idex_rd != 5'd0) &
                      ((hz.idex_rd == hz.id_rs1) | (hz.idex_rd == hz.id_rs2));
   assign lu_stall  = ~freeze & ~br_taken & lu_hazard;

   always_comb begin
      hz.pc_write     = 1'b1;
      hz.pc_src       = 1'b0;
      hz.ifid_write   = 1'b1;
      hz.ifid_flush   = 1'b0;
      hz.idex_write   = 1'b1;
      hz.idex_flush   = 1'b0;
      hz.exmem_write  = 1'b1;
      hz.exmem_flush  = 1'b0;
      hz.memwb_bubble = 1'b0;
      hz.dmem_req     = memop;
      if (reset) begin
         hz.pc_write     = 1'b0;
         hz.ifid_write   = 1'b0;
         hz.ifid_flush   = 1'b1;
         hz.idex_write   = 1'b0;
         hz.idex_flush   = 1'b1;
         hz.exmem_write  = 1'b0;
         hz.exmem_flush  = 1'b1;
         hz.memwb_bubble = 1'b1;
         hz.dmem_req     = 1'b0;
      end else if (freeze) begin
         hz.pc_write     = 1'b0;
         hz.ifid_write   = 1'b0;
         hz.idex_write   = 1'b0;
         hz.exmem_write  = 1'b0;
         hz.memwb_bubble = 1'b1;
      end else if (br_taken) begin
         hz.pc_src      = 1'b1;
         hz.ifid_flush  = 1'b1;
         hz.idex_flush  = 1'b1;
         hz.exmem_flush = 1'b1;
      end else if (lu_stall) begin
         hz.pc_write   = 1'b0;
         hz.ifid_write = 1'b0;
         hz.idex_flush = 1'b1;
      end
   end

   assign hz.mem_stall = (state == MEM_WAIT);
   assign hz.mem_err   = mem_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (memop && !hz.dmem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WCW'(1);
               end
            end
            MEM_WAIT: begin
               if (hz.dmem_ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (timeout) begin
                  state     <= RUN;
                  wait_cnt  <= '0;
                  mem_err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles    <= '0;
         flush_events    <= '0;
         mem_wait_cycles <= '0;
      end else begin
         if (lu_stall) stall_cycles    <= stall_cycles + CNT_W'(1);
         if (br_taken) flush_events    <= flush_events + CNT_W'(1);
         if (freeze)   mem_wait_cycles <= mem_wait_cycles + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles, flush_events, mem_wait_cycles;
`endif

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.master)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events),
      .mem_wait_cycles (mem_wait_cycles)
`endif
   );

   typedef struct {
      string       tag;
      logic [11:0] v;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   localparam int M_NORM = 0, M_LU = 1, M_BR = 2, M_FRZ = 3, M_RST = 4;

   // {pc_write,pc_src,ifid_write,ifid_flush,idex_write,idex_flush,exmem_write,exmem_flush,memwb_bubble,dmem_req,mem_stall,mem_err}
   function automatic logic [11:0] ev(int mode, bit req, bit stall, bit err);
      logic [8:0] c;
      case (mode)
         M_NORM:  c = 9'b1_0_1_0_1_0_1_0_0;
         M_LU:    c = 9'b0_0_0_0_1_1_1_0_0;
         M_BR:    c = 9'b1_1_1_1_1_1_1_1_0;
         M_FRZ:   c = 9'b0_0_0_0_0_0_0_0_1;
         default: c = 9'b0_0_0_1_0_1_0_1_1;
      endcase
      return {c, req, stall, err};
   endfunction

   function automatic logic [11:0] obs();
      return {hz.pc_write, hz.pc_src, hz.ifid_write, hz.ifid_flush, hz.idex_write,
              hz.idex_flush, hz.exmem_write, hz.exmem_flush, hz.memwb_bubble,
              hz.dmem_req, hz.mem_stall, hz.mem_err};
   endfunction

   task automatic check_val(string tag, logic [63:0] o, logic [63:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Inputs are set just after a rising edge; expectation queued, then compared mid-cycle.
   task automatic cyc(string tag, int mode, bit req, bit stall, bit err);
      exp_t e;
      logic [11:0] o;
      q.push_back('{tag, ev(mode, req, stall, err)});
      #3;
      e = q.pop_front();
      o = obs();
      tests++;
      assert (o === e.v) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", e.tag, o, e.v);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(logic [4:0] rs1, logic [4:0] rs2, logic ldr, logic [4:0] rd,
                         logic br, logic z, logic mr, logic mw, logic rdy);
      hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.idex_memread = ldr; hz.idex_rd = rd;
      hz.exmem_branch = br; hz.exmem_zero = z; hz.exmem_memread = mr;
      hz.exmem_memwrite = mw; hz.dmem_ready = rdy;
   endtask

   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); @(posedge clk); #1;
      cyc("reset_state", M_RST, 0, 0, 0);
      reset = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      check_val("perf_stall_rst", stall_cycles, 0);
      check_val("perf_flush_rst", flush_events, 0);
      check_val("perf_memw_rst", mem_wait_cycles, 0);
`endif
      cyc("idle", M_NORM, 0, 0, 0);

      set_in(0, 5, 1, 5, 0, 0, 0, 0, 0);
      cyc("lu_rs2", M_LU, 0, 0, 0);
      set_in(0, 5, 0, 5, 0, 0, 0, 0, 0);
      cyc("lu_release", M_NORM, 0, 0, 0);
      set_in(7, 3, 1, 7, 0, 0, 0, 0, 0);
      cyc("lu_rs1", M_LU, 0, 0, 0);
      set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
      cyc("lu_x0", M_NORM, 0, 0, 0);
      set_in(9, 9, 1, 8, 0, 0, 0, 0, 0);
      cyc("lu_nomatch", M_NORM, 0, 0, 0);

      set_in(0, 0, 0, 0, 1, 1, 0, 0, 0);
      cyc("br_taken", M_BR, 0, 0, 0);
      set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
      cyc("br_not_taken", M_NORM, 0, 0, 0);

      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc("mw_frz1", M_FRZ, 1, 0, 0);
      cyc("mw_frz2", M_FRZ, 1, 1, 0);
      cyc("mw_frz3", M_FRZ, 1, 1, 0);
      hz.dmem_ready = 1'b1;
      cyc("mw_ready", M_NORM, 1, 1, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("mw_back_run", M_NORM, 0, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
      cyc("zero_wait", M_NORM, 1, 0, 0);

      set_in(4, 0, 1, 4, 1, 1, 0, 0, 0);
      cyc("prio_br_over_lu", M_BR, 0, 0, 0);
      set_in(0, 0, 0, 0, 1, 1, 1, 0, 0);
      cyc("prio_frz_over_br", M_FRZ, 1, 0, 0);
      hz.dmem_ready = 1'b1;
      cyc("prio_br_after_rel", M_BR, 1, 1, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("prio_idle", M_NORM, 0, 0, 0);

      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc("to_frz_run", M_FRZ, 1, 0, 0);
      for (int i = 1; i <= 14; i++) cyc($sformatf("to_frz_%0d", i), M_FRZ, 1, 1, 0);
      cyc("to_release", M_NORM, 1, 1, 0);
      hz.exmem_memread = 1'b0;
      cyc("to_err_set", M_NORM, 0, 0, 1);
      cyc("to_err_sticky", M_NORM, 0, 0, 1);

      hz.exmem_memread = 1'b1;
      cyc("rmw_frz1", M_FRZ, 1, 0, 1);
      cyc("rmw_frz2", M_FRZ, 1, 1, 1);
      reset = 1'b1;
      cyc("rmw_reset1", M_RST, 0, 1, 1);
      cyc("rmw_reset2", M_RST, 0, 0, 0);
      reset = 1'b0;
      hz.exmem_memread = 1'b0;
      cyc("rmw_after", M_NORM, 0, 0, 0);
      check_val("rmw_wait_cnt", 64'(dut.wait_cnt), 0);
`ifdef HAZARD_PERF_CNT_EN
      check_val("perf_stall_rst2", stall_cycles, 0);
      check_val("perf_memw_rst2", mem_wait_cycles, 0);
      set_in(0, 5, 1, 5, 0, 0, 0, 0, 0);
      cyc("perf_lu", M_LU, 0, 0, 0);
      check_val("perf_stall_inc", stall_cycles, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
